ase_svfifo_thresh: RTL and testbench
====================================

ASE_SVFIFO_THRESH -- requirements
Module: ase_svfifo_thresh

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, bits per entry.
REQ-002 SHALL have parameter DEPTH_BASE2, default 3, log2 of entry count (DEPTH = 2**DEPTH_BASE2).
REQ-003 SHALL have parameter ALMFULL_THRESH, default DEPTH-2, count at or above which alm_full asserts.
REQ-004 SHALL have parameter ALMEMPTY_THRESH, default 2, count at or below which alm_empty asserts.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write request, data_in sampled same edge.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  read data, qualified by data_valid.
REQ-011 SHALL have port data_valid  output  1  data_out valid this cycle.
REQ-012 SHALL have ports full, alm_full, empty, alm_empty  output  1 each  occupancy flags.
REQ-013 SHALL have port count  output  DEPTH_BASE2+1  current occupancy 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  dropped write / ignored read indicators.

Function
REQ-015 Write accepted iff wr_en and count<DEPTH at the edge; entry stored at write pointer, pointer increments modulo DEPTH.
REQ-016 Read accepted iff rd_en and count>0 at the edge; data_out/data_valid presented exactly one cycle later (latency 1, no fall-through).
REQ-017 data_valid SHALL be high for one cycle per accepted read; data_out holds last value when data_valid low.
REQ-018 count next = count + accepted_write - accepted_read; simultaneous accepted read and write leave count unchanged.
REQ-019 When full, wr_en is dropped even if rd_en asserted the same cycle; overflow pulses next cycle.
REQ-020 When empty, rd_en is ignored even if wr_en asserted the same cycle; write accepted, underflow pulses next cycle, no data_valid.
REQ-021 Flags SHALL be registered and consistent with count: full=(count==DEPTH), empty=(count==0), alm_full=(count>=ALMFULL_THRESH), alm_empty=(count<=ALMEMPTY_THRESH).
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 without data loss; order strictly first-in first-out.

Reset
REQ-023 On rst high at an edge: pointers=0, count=0, empty=1, alm_empty=1, full=0, alm_full=0, data_valid=0, overflow=0, underflow=0; data_out value undefined-but-stable (no reset required on storage).
REQ-024 Reset mid-operation SHALL discard all contents; a read accepted on the edge before reset SHALL NOT produce data_valid after reset.
REQ-025 wr_en/rd_en asserted while rst high SHALL have no effect.

Configuration
REQ-026 Macro ASE_FIFO_STICKY_ERR_EN defined: overflow/underflow SHALL be sticky, held high until rst.
REQ-027 Macro undefined: overflow/underflow SHALL be single-cycle pulses per offending request.

Structure
REQ-028 Package ase_fifo_pkg SHALL hold the pointer/count width helper function and flag-struct typedef (full, alm_full, empty, alm_empty).
REQ-029 Storage SHALL be sub-module ase_fifo_ram: simple dual-port, one write port, one registered read port, DATA_WIDTH x DEPTH.
REQ-030 Parameter legality (ALMEMPTY_THRESH < ALMFULL_THRESH <= DEPTH) SHALL be checked at elaboration with a fatal message.

Verification
REQ-031 Defaults, write 8 words 0xCAFEBABE_00000000+i, no reads -> count=8, full=1, alm_full at count 6, 9th write raises overflow.
REQ-032 Read all 8 back -> data_valid 1 cycle after each rd_en, data_out in order +0..+7, empty=1 after last, alm_empty at count 2.
REQ-033 Continuous wr_en and rd_en for 256 words at DEPTH_BASE2=3 -> every word read exactly once in order, count never exceeds 8, pointers wrap 32 times.
REQ-034 Full FIFO with wr_en and rd_en same cycle -> oldest word read, write dropped, count 7, overflow asserted.
REQ-035 Empty FIFO with wr_en and rd_en same cycle -> count 1, no data_valid, underflow asserted; sticky vs pulse checked in both macro builds.
REQ-036 rst asserted with count=5 and a read in flight -> count=0, empty=1, no data_valid on following cycles.

Source files
------------

// File: rtl/ase_fifo_pkg.sv
// Shared width helpers and occupancy-flag bundle for the ase FIFO family.
package ase_fifo_pkg;

    typedef struct packed {
        logic full;
        logic alm_full;
        logic empty;
        logic alm_empty;
    } ase_fifo_flags_t;

    // The count needs one bit more than a pointer so it can hold DEPTH itself
    function automatic int ase_fifo_cnt_w(input int depth_base2);
        return depth_base2 + 1;
    endfunction

    function automatic int ase_fifo_ptr_w(input int depth_base2);
        return (depth_base2 < 1) ? 1 : depth_base2;
    endfunction

endpackage

// File: rtl/ase_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset on contents.
module ase_fifo_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read register only loads on a read, so it holds the last word otherwise
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ase_svfifo_thresh.sv
// Synchronous FIFO with registered almost-full/almost-empty flags and 1-cycle read latency.
// Define ASE_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until reset.
module ase_svfifo_thresh
    import ase_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int DEPTH_BASE2     = 3,
    parameter int ALMFULL_THRESH  = (2**DEPTH_BASE2) - 2,
    parameter int ALMEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  alm_full,
    output logic                  empty,
    output logic                  alm_empty,
    output logic [DEPTH_BASE2:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**DEPTH_BASE2;
    localparam int CW    = ase_fifo_cnt_w(DEPTH_BASE2);
    localparam int PW    = ase_fifo_ptr_w(DEPTH_BASE2);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMEMPTY_THRESH);

    if (DEPTH_BASE2 < 1 || ALMEMPTY_THRESH < 0 || ALMEMPTY_THRESH >= ALMFULL_THRESH
        || ALMFULL_THRESH > DEPTH) begin : g_bad_params
        $fatal(1, "ase_svfifo_thresh: need DEPTH_BASE2>=1 and 0<=ALMEMPTY_THRESH<ALMFULL_THRESH<=DEPTH");
    end

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    ase_fifo_flags_t flags_q, flags_d;
    logic            valid_q, ovf_q, unf_q, ovf_d, unf_d;
    logic            wr_acc, rd_acc;

    // Acceptance looks only at the occupancy before the edge, so a read never frees
    // room for a same-cycle write and a write never feeds a same-cycle read.
    assign wr_acc = wr_en && !rst && (count_q != DEPTH_C);
    assign rd_acc = rd_en && !rst && (count_q != '0);

    always_comb begin
        count_d           = count_q + CW'(wr_acc) - CW'(rd_acc);
        flags_d.full      = (count_d == DEPTH_C);
        flags_d.alm_full  = (count_d >= AF_C);
        flags_d.empty     = (count_d == '0);
        flags_d.alm_empty = (count_d <= AE_C);
`ifdef ASE_FIFO_STICKY_ERR_EN
        ovf_d = ovf_q || (wr_en && (count_q == DEPTH_C));
        unf_d = unf_q || (rd_en && (count_q == '0));
`else
        ovf_d = wr_en && (count_q == DEPTH_C);
        unf_d = rd_en && (count_q == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '{full: 1'b0, alm_full: 1'b0, empty: 1'b1, alm_empty: 1'b1};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            flags_q <= flags_d;
            valid_q <= rd_acc;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ase_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

    assign data_valid = valid_q;
    assign full       = flags_q.full;
    assign alm_full   = flags_q.alm_full;
    assign empty      = flags_q.empty;
    assign alm_empty  = flags_q.alm_empty;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_ase_svfifo_thresh.sv
// Directed self-checking bench for ase_svfifo_thresh at default parameters.
module tb_ase_svfifo_thresh;

`ifdef ASE_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [63:0] data_in, data_out;
    logic        data_valid, full, alm_full, empty, alm_empty, overflow, underflow;
    logic [3:0]  count;

    int vecs = 0;
    int errs = 0;

    ase_svfifo_thresh dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .data_valid(data_valid), .full(full), .alm_full(alm_full),
        .empty(empty), .alm_empty(alm_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [63:0] exp_q[$];
    logic [63:0] w;
    int          sent, rcvd, cyc;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_alm_empty", alm_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alm_full", alm_full, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1'b0;

        // Fill with eight words, watching the threshold flags move
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = 64'hCAFEBABE_00000000 + 64'(i);
            step();
            chk("fill_count", count, 64'(i + 1));
            chk("fill_full", full, (i == 7) ? 1 : 0);
            chk("fill_alm_full", alm_full, (i >= 5) ? 1 : 0);
            chk("fill_alm_empty", alm_empty, (i <= 1) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end
        data_in = 64'h1111_2222_3333_4444;
        step();
        chk("ovf_count", count, 8);
        chk("ovf_pulse", overflow, 1);
        wr_en = 1'b0;
        step();
        chk("ovf_after", overflow, STICKY ? 1 : 0);

        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            chk("drain_valid", data_valid, 1);
            chk("drain_data", data_out, 64'hCAFEBABE_00000000 + 64'(i));
            chk("drain_count", count, 64'(7 - i));
            chk("drain_alm_empty", alm_empty, (i >= 5) ? 1 : 0);
            chk("drain_empty", empty, (i == 7) ? 1 : 0);
        end
        rd_en = 1'b0;
        step();
        chk("idle_valid", data_valid, 0);
        chk("idle_hold", data_out, 64'hCAFEBABE_00000007);

        // Empty FIFO, simultaneous write and read: only the write lands
        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; data_in = 64'h0000_0000_ABCD_0001;
        step();
        chk("empwr_count", count, 1);
        chk("empwr_valid", data_valid, 0);
        chk("empwr_unf", underflow, 1);
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        chk("empwr_unf_after", underflow, STICKY ? 1 : 0);
        chk("empwr_valid2", data_valid, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("empwr_rd_valid", data_valid, 1);
        chk("empwr_rd_data", data_out, 64'h0000_0000_ABCD_0001);
        chk("empwr_rd_count", count, 0);

        // Full FIFO, simultaneous write and read: oldest word out, write dropped
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = 64'h5A00_0000_0000_0000 + 64'(i);
            step();
        end
        chk("fullrw_pre", full, 1);
        rd_en = 1'b1; data_in = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        wr_en = 1'b0;
        chk("fullrw_count", count, 7);
        chk("fullrw_ovf", overflow, 1);
        chk("fullrw_valid", data_valid, 1);
        chk("fullrw_data", data_out, 64'h5A00_0000_0000_0000);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("fullrw_drain", data_out, 64'h5A00_0000_0000_0000 + 64'(i));
        end
        rd_en = 1'b0;
        step();
        chk("fullrw_empty", empty, 1);

        // Streaming: continuous write and read of 256 words through the wrapping pointers
        do_reset();
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 256 && cyc < 600) begin
            wr_en = (sent < 256);
            rd_en = 1'b1;
            w = 64'h1234_0000_0000_0000 + 64'(sent * 3 + 7);
            data_in = w;
            if (sent < 256) begin
                exp_q.push_back(w);
                sent++;
            end
            step();
            cyc++;
            chk("stream_le8", (count <= 4'd8) ? 1 : 0, 1);
            if (data_valid) begin
                chk("stream_data", data_out, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx);
                rcvd++;
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("stream_rcvd", 64'(rcvd), 256);
        step();
        chk("stream_empty", empty, 1);

        // Reset with count=5 and a read in flight; enables held during reset are ignored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; data_in = 64'(i);
            step();
        end
        wr_en = 1'b0;
        chk("rst5_count", count, 5);
        rd_en = 1'b1;
        step();
        chk("rst5_inflight", data_valid, 1);
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        step();
        chk("rst5_count0", count, 0);
        chk("rst5_empty", empty, 1);
        chk("rst5_valid", data_valid, 0);
        step();
        chk("rst5_hold_count", count, 0);
        chk("rst5_hold_valid", data_valid, 0);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        step();
        chk("rst5_post_valid", data_valid, 0);
        chk("rst5_post_count", count, 0);
        chk("rst5_post_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
